memory_bus_responder: RTL and testbench

- Target/slave end of the MemoryBus request/response protocol: a word-addressed on-chip RAM.
- Takes packets from the request channel and clears request_busy through a one-cycle accept pulse.
- Performs the read or write after a fixed latency. For reads, returns a bus_read_response packet on the response channel once response_busy is clear.
- Sits behind the bus opposite the cache/fetch initiators, which use send_read_request_data / send_write_request_data / get_response.

---
 rtl/memory_bus_responder.sv | 174 +++++++++++++++++
 tb/tb_memory_bus_responder.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_bus_responder.sv
// Target end of the MemoryBus: a word-addressed RAM that accepts one request at a time,
// performs it after a fixed latency and returns a read response on the response channel.
module memory_bus_responder #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 64,
  parameter int BUS_ID_WIDTH = 4,
  parameter int DEPTH        = 256,
  parameter int LATENCY      = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_busy_i,
  input  logic [1:0]              req_type_i,
  input  logic [BUS_ID_WIDTH-1:0] req_source_i,
  input  logic [ADDR_WIDTH-1:0]   req_address_i,
  input  logic [DATA_WIDTH-1:0]   req_payload_i,
  output logic                    req_accept_o,
  input  logic                    resp_busy_i,
  output logic                    resp_send_o,
  output logic [1:0]              resp_type_o,
  output logic [BUS_ID_WIDTH-1:0] resp_source_o,
  output logic [ADDR_WIDTH-1:0]   resp_address_o,
  output logic [DATA_WIDTH-1:0]   resp_payload_o,
  output logic                    idle_o,
  output logic [7:0]              drop_count_o
);

  localparam int OFF   = $clog2(DATA_WIDTH / 8);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [1:0] PKT_READ      = 2'd0;
  localparam logic [1:0] PKT_WRITE     = 2'd1;
  localparam logic [1:0] PKT_READ_RESP = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESPOND
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [1:0]              pkt_type_q, pkt_type_d;
  logic [BUS_ID_WIDTH-1:0] pkt_source_q, pkt_source_d;
  logic [ADDR_WIDTH-1:0]   pkt_address_q, pkt_address_d;
  logic [DATA_WIDTH-1:0]   pkt_payload_q, pkt_payload_d;
  logic [1:0]              resp_type_q, resp_type_d;
  logic [BUS_ID_WIDTH-1:0] resp_source_q, resp_source_d;
  logic [ADDR_WIDTH-1:0]   resp_address_q, resp_address_d;
  logic [DATA_WIDTH-1:0]   rd_data_q;
  logic [7:0]              drop_count_q, drop_count_d;

  logic                    req_accept;
  logic                    resp_send;
  logic                    mem_we;
  logic                    mem_re;
  logic [IDX_W-1:0]        idx;

  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  // Offset and upper address bits are ignored, so addresses alias modulo DEPTH words.
  assign idx = pkt_address_q[OFF+IDX_W-1:OFF];

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    pkt_type_d     = pkt_type_q;
    pkt_source_d   = pkt_source_q;
    pkt_address_d  = pkt_address_q;
    pkt_payload_d  = pkt_payload_q;
    resp_type_d    = resp_type_q;
    resp_source_d  = resp_source_q;
    resp_address_d = resp_address_q;
    drop_count_d   = drop_count_q;
    req_accept     = 1'b0;
    resp_send      = 1'b0;
    mem_we         = 1'b0;
    mem_re         = 1'b0;

    case (state_q)
      S_IDLE: begin
        req_accept = req_busy_i;
        if (req_busy_i) begin
          pkt_type_d    = req_type_i;
          pkt_source_d  = req_source_i;
          pkt_address_d = req_address_i;
          pkt_payload_d = req_payload_i;
          cnt_d         = CNT_W'(LATENCY - 1);
          if (req_type_i == PKT_READ || req_type_i == PKT_WRITE) begin
            state_d = S_WAIT;
          end else if (drop_count_q != 8'hFF) begin
            drop_count_d = drop_count_q + 8'd1;
          end
        end
      end

      S_WAIT: begin
        if (cnt_q == '0) begin
          if (pkt_type_q == PKT_WRITE) begin
            mem_we  = 1'b1;
            state_d = S_IDLE;
          end else begin
            mem_re         = 1'b1;
            resp_type_d    = PKT_READ_RESP;
            resp_source_d  = pkt_source_q;
            resp_address_d = pkt_address_q;
            state_d        = S_RESPOND;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_RESPOND: begin
        resp_send = !resp_busy_i;
        if (!resp_busy_i) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      pkt_type_q     <= '0;
      pkt_source_q   <= '0;
      pkt_address_q  <= '0;
      pkt_payload_q  <= '0;
      resp_type_q    <= '0;
      resp_source_q  <= '0;
      resp_address_q <= '0;
      drop_count_q   <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      pkt_type_q     <= pkt_type_d;
      pkt_source_q   <= pkt_source_d;
      pkt_address_q  <= pkt_address_d;
      pkt_payload_q  <= pkt_payload_d;
      resp_type_q    <= resp_type_d;
      resp_source_q  <= resp_source_d;
      resp_address_q <= resp_address_d;
      drop_count_q   <= drop_count_d;
    end
  end

  // RAM contents survive reset; a write still in flight when reset arrives is discarded.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      mem_q[idx] <= pkt_payload_q;
    end
    if (reset) begin
      rd_data_q <= '0;
    end else if (mem_re) begin
      rd_data_q <= mem_q[idx];
    end
  end

  // Every output is forced low while reset is held, including the combinational handshakes.
  assign req_accept_o   = req_accept & ~reset;
  assign resp_send_o    = resp_send & ~reset;
  assign idle_o         = (state_q == S_IDLE) & ~reset;
  assign resp_type_o    = reset ? '0 : resp_type_q;
  assign resp_source_o  = reset ? '0 : resp_source_q;
  assign resp_address_o = reset ? '0 : resp_address_q;
  assign resp_payload_o = reset ? '0 : rd_data_q;
  assign drop_count_o   = reset ? '0 : drop_count_q;

endmodule

// File: tb/tb_memory_bus_responder.sv
// Self-checking bench for memory_bus_responder: directed protocol scenarios followed by
// randomized traffic compared against a word-array model of the RAM.
module tb_memory_bus_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_busy_i = 1'b0;
  logic [1:0]  req_type_i = 2'd0;
  logic [3:0]  req_source_i = 4'd0;
  logic [31:0] req_address_i = 32'd0;
  logic [63:0] req_payload_i = 64'd0;
  logic        req_accept_o;
  logic        resp_busy_i = 1'b0;
  logic        resp_send_o;
  logic [1:0]  resp_type_o;
  logic [3:0]  resp_source_o;
  logic [31:0] resp_address_o;
  logic [63:0] resp_payload_o;
  logic        idle_o;
  logic [7:0]  drop_count_o;

  int          n_checks = 0;
  int          n_pass = 0;
  int          exp_drops = 0;
  logic [63:0] ref_mem [256];

  memory_bus_responder dut (
    .clk            (clk),
    .reset          (reset),
    .req_busy_i     (req_busy_i),
    .req_type_i     (req_type_i),
    .req_source_i   (req_source_i),
    .req_address_i  (req_address_i),
    .req_payload_i  (req_payload_i),
    .req_accept_o   (req_accept_o),
    .resp_busy_i    (resp_busy_i),
    .resp_send_o    (resp_send_o),
    .resp_type_o    (resp_type_o),
    .resp_source_o  (resp_source_o),
    .resp_address_o (resp_address_o),
    .resp_payload_o (resp_payload_o),
    .idle_o         (idle_o),
    .drop_count_o   (drop_count_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Word index of a byte address: 8-byte words, 256-word RAM.
  function automatic int ref_idx(input logic [31:0] a);
    return int'((a / 32'd8) % 32'd256);
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", tag, got, exp, $time);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_accept"}, req_accept_o, 0);
    check_eq({tag, "_send"}, resp_send_o, 0);
    check_eq({tag, "_type"}, resp_type_o, 0);
    check_eq({tag, "_source"}, resp_source_o, 0);
    check_eq({tag, "_address"}, resp_address_o, 0);
    check_eq({tag, "_payload"}, resp_payload_o, 0);
    check_eq({tag, "_idle"}, idle_o, 0);
    check_eq({tag, "_drops"}, drop_count_o, 0);
  endtask

  task automatic check_resp(input logic [3:0] src, input logic [31:0] addr, input logic [63:0] data);
    check_eq("resp_type", resp_type_o, 2);
    check_eq("resp_source", resp_source_o, src);
    check_eq("resp_address", resp_address_o, addr);
    check_eq("resp_payload", resp_payload_o, data);
  endtask

  // Presents a request and expects it accepted in the same cycle; returns sampled in T+1.
  task automatic issue(input logic [1:0] t, input logic [3:0] src, input logic [31:0] addr,
                       input logic [63:0] data);
    int n;
    n = 0;
    @(negedge clk);
    req_busy_i = 1'b1;
    req_type_i = t;
    req_source_i = src;
    req_address_i = addr;
    req_payload_i = data;
    #1;
    while (req_accept_o !== 1'b1 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    check_eq("accept_latency", n, 0);
    @(negedge clk);
    req_busy_i = 1'b0;
    #1;
  endtask

  task automatic do_write(input logic [3:0] src, input logic [31:0] addr, input logic [63:0] data);
    issue(2'd1, src, addr, data);
    check_eq("wr_idle_t1", idle_o, 0);
    @(negedge clk); #1;
    check_eq("wr_idle_t2", idle_o, 0);
    check_eq("wr_accept_t2", req_accept_o, 0);
    @(negedge clk); #1;
    check_eq("wr_idle_t3", idle_o, 1);
    ref_mem[ref_idx(addr)] = data;
    $display("write src=%0d addr=0x%08h data=0x%016h", src, addr, data);
  endtask

  task automatic do_read(input logic [3:0] src, input logic [31:0] addr, input int busy);
    logic [63:0] exp;
    exp = ref_mem[ref_idx(addr)];
    issue(2'd0, src, addr, 64'd0);
    check_eq("rd_idle_t1", idle_o, 0);
    check_eq("rd_send_t1", resp_send_o, 0);
    @(negedge clk);
    resp_busy_i = (busy > 0);
    #1;
    check_eq("rd_send_t2", resp_send_o, 0);
    for (int k = 0; k < busy; k++) begin
      @(negedge clk); #1;
      check_eq("rd_send_while_busy", resp_send_o, 0);
      check_resp(src, addr, exp);
    end
    @(negedge clk);
    resp_busy_i = 1'b0;
    #1;
    check_eq("rd_send", resp_send_o, 1);
    check_resp(src, addr, exp);
    @(negedge clk); #1;
    check_eq("rd_send_single", resp_send_o, 0);
    check_eq("rd_idle_after", idle_o, 1);
    $display("read  src=%0d addr=0x%08h data=0x%016h busy=%0d", src, addr, resp_payload_o, busy);
  endtask

  task automatic do_bad(input logic [1:0] t);
    issue(t, 4'd1, $urandom, {$urandom, $urandom});
    if (exp_drops < 255) exp_drops++;
    check_eq("bad_idle", idle_o, 1);
    check_eq("bad_send", resp_send_o, 0);
    check_eq("bad_drops", drop_count_o, exp_drops);
    $display("drop  type=%0d drops=%0d", t, drop_count_o);
  endtask

  initial begin
    int sel;
    logic [31:0] a;
    logic [31:0] addr_a;

    // Reset: outputs low even with a request pending on the bus.
    req_busy_i = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    req_busy_i = 1'b0;
    reset = 1'b0;
    #1;
    check_eq("post_reset_idle", idle_o, 1);
    check_eq("post_reset_drops", drop_count_o, 0);
    check_eq("post_reset_payload", resp_payload_o, 0);
    $display("reset released");

    // Reserved / response-typed requests are swallowed.
    do_bad(2'd2);
    do_bad(2'd3);
    check_eq("two_drops", drop_count_o, 2);

    // Basic write then read.
    do_write(4'd2, 32'h10, 64'hDEAD_BEEF_0123_4567);
    do_read(4'd3, 32'h10, 0);
    do_read(4'd3, 32'h10, 4);

    // Aliasing through ignored upper and offset bits.
    do_write(4'd4, 32'h818, 64'h55);
    do_read(4'd6, 32'h18, 0);
    do_read(4'd6, 32'h1C, 1);

    // Back-to-back: request line held with a second read queued behind the first.
    addr_a = 32'h10;
    @(negedge clk);
    req_busy_i = 1'b1; req_type_i = 2'd0; req_source_i = 4'd5; req_address_i = addr_a;
    #1;
    check_eq("b2b_first_accept", req_accept_o, 1);
    @(negedge clk);
    req_source_i = 4'd9; req_address_i = 32'h18;
    #1;
    check_eq("b2b_no_accept_wait1", req_accept_o, 0);
    @(negedge clk); #1;
    check_eq("b2b_no_accept_wait2", req_accept_o, 0);
    @(negedge clk); #1;
    check_eq("b2b_first_send", resp_send_o, 1);
    check_eq("b2b_no_accept_respond", req_accept_o, 0);
    check_resp(4'd5, addr_a, ref_mem[ref_idx(addr_a)]);
    @(negedge clk); #1;
    check_eq("b2b_second_accept", req_accept_o, 1);
    check_eq("b2b_send_gone", resp_send_o, 0);
    @(negedge clk);
    req_busy_i = 1'b0;
    #1;
    check_eq("b2b_wait_a", resp_send_o, 0);
    @(negedge clk); #1;
    check_eq("b2b_wait_b", resp_send_o, 0);
    @(negedge clk); #1;
    check_eq("b2b_second_send", resp_send_o, 1);
    check_resp(4'd9, 32'h18, ref_mem[3]);
    @(negedge clk); #1;
    check_eq("b2b_idle", idle_o, 1);
    $display("b2b   two reads completed");

    // Fill the whole RAM so every later random read has a known expectation.
    for (int i = 0; i < 256; i++) begin
      do_write(4'($urandom), 32'(i * 8), {$urandom, $urandom});
    end

    // Randomized traffic.
    for (int n = 0; n < 150; n++) begin
      sel = $urandom_range(0, 9);
      a = $urandom;
      if (sel < 4) do_read(4'($urandom), a, $urandom_range(0, 3));
      else if (sel < 8) do_write(4'($urandom), a, {$urandom, $urandom});
      else if (sel == 8) do_bad(2'd2);
      else do_bad(2'd3);
    end

    // Saturation of the drop counter.
    for (int n = 0; n < 300; n++) begin
      do_bad(2'($urandom_range(2, 3)));
    end
    check_eq("drops_saturated", drop_count_o, 255);

    // Reset during a write's latency window: the write must not land.
    do_write(4'd1, 32'h20, 64'h11);
    issue(2'd1, 4'd7, 32'h20, 64'hAA);
    reset = 1'b1;
    #1;
    check_all_zero("midreset_a");
    @(negedge clk); #1;
    check_all_zero("midreset_b");
    @(negedge clk);
    reset = 1'b0;
    exp_drops = 0;
    #1;
    check_eq("midreset_idle", idle_o, 1);
    check_eq("midreset_drops", drop_count_o, 0);
    check_eq("midreset_type", resp_type_o, 0);
    $display("reset during write wait");
    do_read(4'd8, 32'h20, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
